// File: rtl/regfile_scrub.sv
// regfile_scrub: parametrised 2-read/1-write register file with a sequential
// scrub walker that zeroes one entry per cycle after reset or on request.
//
// Ports
//   CLK       system clock, all state on rising edge
//   RST_N     synchronous active-low reset (starts a scrub walk)
//   CLR_REQ   request to scrub all entries to 0 (honoured only when idle)
//   A1, A2    combinational read addresses (rs1, rs2)
//   A3        write address (rd)
//   WD        write data
//   RegWrite  write enable
//   RD1, RD2  read data, zero latency
//   BUSY      scrub in progress; writes dropped, reads return 0
//   WR_DROP   registered pulse: a write was attempted last cycle while BUSY
module regfile_scrub #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR_REQ,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY,
  output logic              WR_DROP
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                busy;
  logic                wr_accept;

  assign busy      = (state_q == SCRUB);
  assign wr_accept = RegWrite && !busy && !((ZERO_REG != 0) && (A3 == '0));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_drop_d = RegWrite && busy;
    case (state_q)
      IDLE: begin
        if (CLR_REQ) begin
          state_d = SCRUB;
          ptr_d   = '0;
        end
      end
      SCRUB: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= SCRUB;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage has no reset of its own; the walker clears it once reset is
  // released. Scrub and write never coincide because writes require !busy.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (busy) begin
        mem_q[ptr_q] <= '0;
      end else if (wr_accept) begin
        mem_q[A3] <= WD;
      end
    end
  end

  always_comb begin
    RD1 = mem_q[A1];
    if (busy) begin
      RD1 = '0;
    end else if ((ZERO_REG != 0) && (A1 == '0)) begin
      RD1 = '0;
    end else if ((BYPASS != 0) && wr_accept && (A3 == A1)) begin
      RD1 = WD;
    end
  end

  always_comb begin
    RD2 = mem_q[A2];
    if (busy) begin
      RD2 = '0;
    end else if ((ZERO_REG != 0) && (A2 == '0)) begin
      RD2 = '0;
    end else if ((BYPASS != 0) && wr_accept && (A3 == A2)) begin
      RD2 = WD;
    end
  end

  assign BUSY    = busy;
  assign WR_DROP = wr_drop_q;

endmodule
